// File: rtl/sseg_hex_display.sv
// Multi-channel 2-digit hex display driver for 7-segment Pmods.
// Each channel latches an 8-bit debug value into a shadow register, copies it
// to the display register only on digit-phase boundaries (so a digit never
// tears mid-phase), and time-multiplexes both nibbles. A separate divider
// produces a one-cycle tick for slow-stepping the core.
module sseg_hex_display #(
  parameter int CHANNELS      = 2,
  parameter int REFRESH_DIV   = 12000,
  parameter int TICK_DIV      = 12000000,
  parameter int BLANK_LEADING = 1
) (
  input  logic                  CLK,
  input  logic                  reset,
  input  logic [8*CHANNELS-1:0] din,
  input  logic                  din_valid,
  input  logic                  freeze,
  output logic [8*CHANNELS-1:0] dout,
  output logic                  tick
);

  localparam int RW = $clog2(REFRESH_DIV);
  localparam int TW = $clog2(TICK_DIV);
  localparam logic [RW-1:0] R_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [TW-1:0] T_LAST = TW'(TICK_DIV - 1);

  logic [RW-1:0]         rcnt;
  logic [TW-1:0]         tcnt;
  logic                  sel;
  logic                  boundary;
  logic [8*CHANNELS-1:0] shadow;
  logic [8*CHANNELS-1:0] disp;
  logic [8*CHANNELS-1:0] dout_next;

  // One display byte: {digit_sel, seg[6:0]}, segments active-low {g..a}.
  // Only the left digit may be blanked, so a value of 0 still shows "0".
  function automatic logic [7:0] digit_byte(input logic s, input logic [7:0] v);
    logic [3:0] nib;
    logic [6:0] seg;
    nib = s ? v[7:4] : v[3:0];
    case (nib)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    if (BLANK_LEADING != 0 && s && v[7:4] == 4'h0) seg = 7'h7F;
    return {s, seg};
  endfunction

  assign boundary = (rcnt == R_LAST);

  // Refresh divider: one digit phase every REFRESH_DIV cycles.
  // NOTE: every clocked block uses <= so all registers sample pre-edge values.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) rcnt <= '0;
    else       rcnt <= boundary ? '0 : rcnt + RW'(1);
  end

  // Shadow capture; freeze holds whatever was last latched.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset)                    shadow <= '0;
    else if (din_valid && !freeze) shadow <= din;
  end

  // Digit select and display copy change together, only on a boundary.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      sel  <= 1'b0;
      disp <= '0;
    end else if (boundary) begin
      sel  <= ~sel;
      disp <= shadow;
    end
  end

  // Segment decode for every channel from the shared select.
  // NOTE: dout_next gets a default before the loop so no latch can be inferred.
  always_comb begin
    dout_next = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      dout_next[8*c +: 8] = digit_byte(sel, disp[8*c +: 8]);
    end
  end

  // Registered outputs; reset shows every digit dark with sel = 0.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) dout <= {CHANNELS{8'h7F}};
    else       dout <= dout_next;
  end

  // Tick divider: tick is high the cycle after tcnt reaches its last value.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      tcnt <= '0;
      tick <= 1'b0;
    end else begin
      tcnt <= (tcnt == T_LAST) ? '0 : tcnt + TW'(1);
      tick <= (tcnt == T_LAST);
    end
  end

endmodule
